regfile_access_ctrl: RTL and testbench
======================================

Name: regfile_access_ctrl

Overview:
- Initiator-side controller that drives the single-port register file (selA/selB/selWrite/writeIn/isReading, outA/outB).
- Accepts independent valid/ready read and write request streams from the datapath.
- Serializes them onto the file's read-or-write-per-cycle interface and returns registered read responses with backpressure.
- Sits between the decode/writeback logic and the register file.

Parameters:
REG_ADDRESS_SIZE, 2, register select width
MEM_WORD_SIZE, 64, data word width

Ports:
clk  in  1  single clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
rdReqValid  in  1  read request valid
rdReqReady  out  1  read request accepted this cycle when both valid and ready are high
rdSelA  in  REG_ADDRESS_SIZE  read port A select
rdSelB  in  REG_ADDRESS_SIZE  read port B select
wrReqValid  in  1  write request valid
wrReqReady  out  1  write request accepted (committed) this cycle
wrSel  in  REG_ADDRESS_SIZE  write select
wrData  in  MEM_WORD_SIZE  write data
rdRespValid  out  1  read response valid, registered
rdRespReady  in  1  consumer accepts the response
rdDataA  out  MEM_WORD_SIZE  response data A, registered
rdDataB  out  MEM_WORD_SIZE  response data B, registered
selA  out  REG_ADDRESS_SIZE  to register file
selB  out  REG_ADDRESS_SIZE  to register file
selWrite  out  REG_ADDRESS_SIZE  to register file
writeIn  out  MEM_WORD_SIZE  to register file
isReading  out  1  to register file; 0 means write at this edge
rfOutA  in  MEM_WORD_SIZE  register file outA
rfOutB  in  MEM_WORD_SIZE  register file outB

Behaviour:
- States: IDLE, RD_WAIT (read issued, file output not yet valid), RD_HOLD (response held awaiting rdRespReady).
- Reset (rst_n low, async):
  - State goes to IDLE; rdRespValid=0; rdDataA/B=0; lastGrant=READ.
  - isReading forced to 1 combinationally; selA/selB/selWrite/writeIn forced to 0.
  - No write may reach the file while in reset.
- Default (no grant): isReading=1, selA/selB=0, selWrite=0, writeIn=0. An idle read is harmless.
- Read eligible: state IDLE, or state RD_HOLD with rdRespReady=1 in the same cycle.
- Write eligible: any state.
- Arbitration when both requests are valid and eligible: grant the type not granted last (round-robin via lastGrant). If only one is valid and eligible, grant it.
- Write grant:
  - wrReqReady=1, isReading=0, selWrite=wrSel, writeIn=wrData, all combinational.
  - The file commits at this edge; lastGrant=WRITE.
- Read grant:
  - rdReqReady=1, isReading=1, selA=rdSelA, selB=rdSelB.
  - State goes to RD_WAIT; lastGrant=READ.
- RD_WAIT, one cycle, with no read allowed:
  - At this edge capture rfOutA/rfOutB into rdDataA/B, set rdRespValid=1, go to RD_HOLD.
  - A write may be granted in RD_WAIT because isReading=0 leaves outA/B unchanged. The idle case also reissues no read.
  - The capture at this edge uses the file outputs latched at the previous edge.
- Read latency: request accepted at edge N, rdRespValid=1 after edge N+1 (2 cycles).
- RD_HOLD:
  - rdRespValid and data are stable until rdRespReady=1.
  - On accept with no new read grant, go to IDLE and clear rdRespValid.
  - On accept with a new read grant, go to RD_WAIT and clear rdRespValid.
- Peak read throughput: one per 2 cycles.
- Ordering:
  - A write granted at edge N is visible to a read granted at edge N+1 or later.
  - A read and write to the same register in the same cycle cannot occur (one grant per cycle). No bypass is required.
- rdReqReady and wrReqReady are never both 1 in the same cycle.
- Reset mid-operation: an in-flight read and a held response are discarded. A write presented during reset is not acknowledged.
- Widths are pass-through; there is no arithmetic.

Decomposition:
- Shared package holds: REG_ADDRESS_SIZE and MEM_WORD_SIZE defaults; state encoding localparams (IDLE, RD_WAIT, RD_HOLD); grant-type encoding (READ, WRITE).
- One natural sub-module: rr_arbiter2, a 2-requestor round-robin arbiter holding lastGrant.
- The controller FSM and response register stay in the top module.

Test Plan:
1. Reset then write wrSel=2, wrData=64'hDEAD_BEEF -> wrReqReady=1 and isReading=0 that cycle. A read with rdSelA=2, rdSelB=0 one cycle later gives rdRespValid two cycles later with rdDataA=64'hDEAD_BEEF and rdDataB=0.
2. rdReqValid and wrReqValid held high continuously, lastGrant=READ after reset -> grants alternate write, read, write, and so on. There is never a simultaneous ready and no starvation over 20 cycles.
3. Response backpressure: rdRespReady=0 for 5 cycles after the response -> rdRespValid and rdDataA/B are stable and rdReqReady=0. Writes are still accepted with no corruption of the held data. Raising rdRespReady with a pending read gives a same-cycle read grant.
4. Read issued, then a write to the same register (wrSel=1, wrData=5) in RD_WAIT -> the response returns the old value of reg 1. The next read returns 5.
5. Assert rst_n=0 in RD_WAIT and in RD_HOLD, with wrReqValid=1 -> rdRespValid drops immediately and isReading=1. No write is committed and no stale response appears after release.
6. Back-to-back reads to regs 0..3 preloaded 10..13 -> responses arrive in order, 10..13, one every 2 cycles with rdRespReady=1.

Source files
------------

// File: rtl/regfile_access_ctrl_pkg.sv
// Shared definitions for the register-file access controller.
package regfile_access_ctrl_pkg;

    // Default widths of the register select and data word.
    localparam int unsigned REG_ADDRESS_SIZE_DEF = 2;
    localparam int unsigned MEM_WORD_SIZE_DEF    = 64;

    // Controller state encoding (kept as plain constants for legacy tooling).
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_HOLD = 2'd2;

    // Grant type remembered by the round-robin arbiter.
    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } grantType_t;

    // Round-robin pick when both requestors compete: favour the one not served last.
    function automatic grantType_t rrPick(input grantType_t lastGrant);
        return (lastGrant == READ) ? WRITE : READ;
    endfunction

endpackage

// File: rtl/regfile_access_ctrl_rr_arbiter2.sv
// Two-requestor round-robin arbiter (read vs write) holding the last grant type.
module rr_arbiter2
    import regfile_access_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic reqRead,
    input  logic reqWrite,
    output logic grantRead,
    output logic grantWrite
);

    grantType_t lastGrant;

    // Pick at most one requestor; alternate when both compete.
    always_comb begin
        grantRead  = 1'b0;
        grantWrite = 1'b0;
        if (reqRead && reqWrite) begin
            if (rrPick(lastGrant) == WRITE) begin
                grantWrite = 1'b1;
            end else begin
                grantRead = 1'b1;
            end
        end else begin
            grantRead  = reqRead;
            grantWrite = reqWrite;
        end
    end

    // Remember which type was served so the other one wins the next tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lastGrant <= READ;
        end else if (grantWrite) begin
            lastGrant <= WRITE;
        end else if (grantRead) begin
            lastGrant <= READ;
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller serializing read/write requests onto a
// single-port register file and returning registered read responses.
module regfile_access_ctrl
    import regfile_access_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDRESS_SIZE = REG_ADDRESS_SIZE_DEF,
    parameter int unsigned MEM_WORD_SIZE    = MEM_WORD_SIZE_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        rdReqValid,
    output logic                        rdReqReady,
    input  logic [REG_ADDRESS_SIZE-1:0] rdSelA,
    input  logic [REG_ADDRESS_SIZE-1:0] rdSelB,
    input  logic                        wrReqValid,
    output logic                        wrReqReady,
    input  logic [REG_ADDRESS_SIZE-1:0] wrSel,
    input  logic [MEM_WORD_SIZE-1:0]    wrData,
    output logic                        rdRespValid,
    input  logic                        rdRespReady,
    output logic [MEM_WORD_SIZE-1:0]    rdDataA,
    output logic [MEM_WORD_SIZE-1:0]    rdDataB,
    output logic [REG_ADDRESS_SIZE-1:0] selA,
    output logic [REG_ADDRESS_SIZE-1:0] selB,
    output logic [REG_ADDRESS_SIZE-1:0] selWrite,
    output logic [MEM_WORD_SIZE-1:0]    writeIn,
    output logic                        isReading,
    input  logic [MEM_WORD_SIZE-1:0]    rfOutA,
    input  logic [MEM_WORD_SIZE-1:0]    rfOutB
);

    logic [1:0] state;
    logic       rdEligible;
    logic       reqRead;
    logic       reqWrite;
    logic       grantRead;
    logic       grantWrite;

    // A read may issue from IDLE, or from RD_HOLD when the held response leaves this cycle.
    // Requests are gated by rst_n so nothing is granted (and no write reaches the file) in reset.
    always_comb begin
        rdEligible = (state == IDLE) || ((state == RD_HOLD) && rdRespReady);
        reqRead    = rst_n && rdReqValid && rdEligible;
        reqWrite   = rst_n && wrReqValid;
    end

    rr_arbiter2 uArb (
        .clk        (clk),
        .rst_n      (rst_n),
        .reqRead    (reqRead),
        .reqWrite   (reqWrite),
        .grantRead  (grantRead),
        .grantWrite (grantWrite)
    );

    // Drive the register file and the request handshakes from the current grant.
    always_comb begin
        rdReqReady = 1'b0;
        wrReqReady = 1'b0;
        isReading  = 1'b1;
        selA       = '0;
        selB       = '0;
        selWrite   = '0;
        writeIn    = '0;
        if (grantWrite) begin
            wrReqReady = 1'b1;
            isReading  = 1'b0;
            selWrite   = wrSel;
            writeIn    = wrData;
        end else if (grantRead) begin
            rdReqReady = 1'b1;
            selA       = rdSelA;
            selB       = rdSelB;
        end
    end

    // Read FSM and response register; RD_WAIT captures what the file latched at the issuing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rdRespValid <= 1'b0;
            rdDataA     <= '0;
            rdDataB     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grantRead) begin
                        state <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    rdDataA     <= rfOutA;
                    rdDataB     <= rfOutB;
                    rdRespValid <= 1'b1;
                    state       <= RD_HOLD;
                end
                RD_HOLD: begin
                    if (rdRespReady) begin
                        rdRespValid <= 1'b0;
                        state       <= grantRead ? RD_WAIT : IDLE;
                    end
                end
                default: begin
                    rdRespValid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;

    logic        clk;
    logic        rst_n;
    logic        rdReqValid;
    logic        rdReqReady;
    logic [1:0]  rdSelA;
    logic [1:0]  rdSelB;
    logic        wrReqValid;
    logic        wrReqReady;
    logic [1:0]  wrSel;
    logic [63:0] wrData;
    logic        rdRespValid;
    logic        rdRespReady;
    logic [63:0] rdDataA;
    logic [63:0] rdDataB;
    logic [1:0]  selA;
    logic [1:0]  selB;
    logic [1:0]  selWrite;
    logic [63:0] writeIn;
    logic        isReading;
    logic [63:0] rfOutA;
    logic [63:0] rfOutB;

    regfile_access_ctrl #(.REG_ADDRESS_SIZE(2), .MEM_WORD_SIZE(64)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdReqValid  (rdReqValid),
        .rdReqReady  (rdReqReady),
        .rdSelA      (rdSelA),
        .rdSelB      (rdSelB),
        .wrReqValid  (wrReqValid),
        .wrReqReady  (wrReqReady),
        .wrSel       (wrSel),
        .wrData      (wrData),
        .rdRespValid (rdRespValid),
        .rdRespReady (rdRespReady),
        .rdDataA     (rdDataA),
        .rdDataB     (rdDataB),
        .selA        (selA),
        .selB        (selB),
        .selWrite    (selWrite),
        .writeIn     (writeIn),
        .isReading   (isReading),
        .rfOutA      (rfOutA),
        .rfOutB      (rfOutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port register file: read-or-write each edge.
    logic [63:0] rfMem [4];
    initial begin
        for (int i = 0; i < 4; i++) rfMem[i] = '0;
        rfOutA = '0;
        rfOutB = '0;
    end
    always @(posedge clk) begin
        if (isReading) begin
            rfOutA <= rfMem[selA];
            rfOutB <= rfMem[selB];
        end else begin
            rfMem[selWrite] <= writeIn;
        end
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (!ok) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: architectural register contents and pending read responses.
    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        int          cyc;
    } exp_t;
    logic [63:0] refMem [4];
    exp_t        q[$];
    bit          respSeen = 0;
    int          cycleCnt = 0;

    initial for (int i = 0; i < 4; i++) refMem[i] = '0;

    // Monitor: observes handshakes, maintains the model, checks responses.
    always @(negedge clk) begin
        cycleCnt++;
        if (!rst_n) begin
            chk(isReading === 1'b1, "rst_isReading", 64'(isReading), 64'd1);
            chk(rdRespValid === 1'b0, "rst_rdRespValid", 64'(rdRespValid), 64'd0);
            chk(!rdReqReady && !wrReqReady, "rst_ready", {62'd0, rdReqReady, wrReqReady}, 64'd0);
            chk(rdDataA == 64'd0 && rdDataB == 64'd0, "rst_rdData", rdDataA | rdDataB, 64'd0);
            chk(selWrite == 2'd0 && writeIn == 64'd0, "rst_writeIn", writeIn, 64'd0);
            q.delete();
            respSeen = 0;
        end else begin
            chk(!(rdReqReady && wrReqReady), "both_ready", {62'd0, rdReqReady, wrReqReady}, 64'd0);
            if (rdRespValid && !rdRespReady)
                chk(!rdReqReady, "rd_ready_while_held", 64'(rdReqReady), 64'd0);
            // Response side
            if (rdRespValid) begin
                if (q.size() == 0) begin
                    chk(1'b0, "stale_response", 64'(rdRespValid), 64'd0);
                end else begin
                    if (!respSeen)
                        chk(cycleCnt == q[0].cyc, "resp_latency", 64'(cycleCnt), 64'(q[0].cyc));
                    respSeen = 1;
                    chk(rdDataA == q[0].a, "resp_dataA", rdDataA, q[0].a);
                    chk(rdDataB == q[0].b, "resp_dataB", rdDataB, q[0].b);
                    if (rdRespReady) begin
                        void'(q.pop_front());
                        respSeen = 0;
                    end
                end
            end else if (q.size() != 0 && !respSeen) begin
                chk(cycleCnt < q[0].cyc, "resp_missing", 64'(cycleCnt), 64'(q[0].cyc));
            end
            // Request side
            if (rdReqReady) begin
                chk(rdReqValid && isReading && selA == rdSelA && selB == rdSelB,
                    "rd_grant_drive", {60'd0, selA, selB}, {60'd0, rdSelA, rdSelB});
                q.push_back('{a: refMem[rdSelA], b: refMem[rdSelB], cyc: cycleCnt + 2});
            end
            if (wrReqReady) begin
                chk(wrReqValid && !isReading && selWrite == wrSel && writeIn == wrData,
                    "wr_grant_drive", writeIn, wrData);
                refMem[wrSel] = wrData;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doWrite(input logic [1:0] sel, input logic [63:0] data);
        bit ok = 0;
        wrReqValid = 1'b1;
        wrSel      = sel;
        wrData     = data;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (wrReqReady) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "wr_accept_timeout", 64'(ok), 64'd1);
        tick();
        wrReqValid = 1'b0;
    endtask

    task automatic doRead(input logic [1:0] a, input logic [1:0] b);
        bit ok = 0;
        rdReqValid = 1'b1;
        rdSelA     = a;
        rdSelB     = b;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (rdReqReady) begin
                ok = 1;
                break;
            end
        end
        chk(ok, "rd_accept_timeout", 64'(ok), 64'd1);
        tick();
        rdReqValid = 1'b0;
    endtask

    task automatic drain();
        for (int n = 0; n < 60; n++) begin
            tick();
            if (q.size() == 0 && !rdRespValid) break;
        end
        chk(q.size() == 0, "drain_timeout", 64'(q.size()), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lastN;
        int idx;
        int kind;
        int prevKind;
        rst_n       = 1'b1;
        rdReqValid  = 1'b0;
        rdSelA      = '0;
        rdSelB      = '0;
        wrReqValid  = 1'b0;
        wrSel       = '0;
        wrData      = '0;
        rdRespReady = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // 1: write then read back with fixed expectation
        doWrite(2'd2, 64'hDEAD_BEEF);
        doRead(2'd2, 2'd0);
        @(negedge clk);
        chk(!rdRespValid, "t1_not_yet_valid", 64'(rdRespValid), 64'd0);
        @(negedge clk);
        chk(rdRespValid, "t1_valid", 64'(rdRespValid), 64'd1);
        chk(rdDataA == 64'hDEAD_BEEF, "t1_dataA", rdDataA, 64'hDEAD_BEEF);
        chk(rdDataB == 64'd0, "t1_dataB", rdDataB, 64'd0);
        tick();
        drain();

        // 2: both streams always valid -> strict alternation starting with write
        rdReqValid = 1'b1;
        wrReqValid = 1'b1;
        prevKind   = 0;
        for (int i = 0; i < 20; i++) begin
            rdSelA = 2'($urandom_range(3));
            rdSelB = 2'($urandom_range(3));
            wrSel  = 2'($urandom_range(3));
            wrData = {$urandom, $urandom};
            @(negedge clk);
            kind = wrReqReady ? 1 : (rdReqReady ? 2 : 0);
            chk(kind != 0, "t2_grant_every_cycle", 64'(kind), 64'd1);
            if (i == 0) chk(kind == 1, "t2_first_is_write", 64'(kind), 64'd1);
            else        chk(kind != prevKind, "t2_alternate", 64'(kind), 64'(3 - prevKind));
            prevKind = kind;
            tick();
        end
        rdReqValid = 1'b0;
        wrReqValid = 1'b0;
        drain();

        // 3: response backpressure with writes flowing
        rdRespReady = 1'b0;
        doRead(2'd3, 2'd2);
        tick();
        rdReqValid = 1'b1;
        rdSelA     = 2'd0;
        rdSelB     = 2'd1;
        wrReqValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wrSel  = 2'($urandom_range(3));
            wrData = {$urandom, $urandom};
            @(negedge clk);
            chk(rdRespValid, "t3_held_valid", 64'(rdRespValid), 64'd1);
            chk(!rdReqReady, "t3_no_read", 64'(rdReqReady), 64'd0);
            chk(wrReqReady, "t3_write_ok", 64'(wrReqReady), 64'd1);
            tick();
        end
        wrReqValid  = 1'b0;
        rdRespReady = 1'b1;
        @(negedge clk);
        chk(rdReqReady, "t3_same_cycle_grant", 64'(rdReqReady), 64'd1);
        tick();
        rdReqValid = 1'b0;
        drain();

        // 4: write in RD_WAIT to the register being read
        doWrite(2'd1, 64'd7);
        doRead(2'd1, 2'd1);
        wrReqValid = 1'b1;
        wrSel      = 2'd1;
        wrData     = 64'd5;
        @(negedge clk);
        chk(wrReqReady, "t4_write_in_rd_wait", 64'(wrReqReady), 64'd1);
        tick();
        wrReqValid = 1'b0;
        @(negedge clk);
        chk(rdRespValid && rdDataA == 64'd7, "t4_old_value", rdDataA, 64'd7);
        tick();
        drain();
        doRead(2'd1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk(rdRespValid && rdDataA == 64'd5, "t4_new_value", rdDataA, 64'd5);
        tick();
        drain();

        // 5a: reset in RD_WAIT with a write pending
        doRead(2'd0, 2'd3);
        wrReqValid = 1'b1;
        wrSel      = 2'd2;
        wrData     = 64'hBAD;
        rst_n      = 1'b0;
        #1;
        chk(isReading && !wrReqReady, "t5_wait_rst_outputs", {62'd0, isReading, wrReqReady}, 64'd2);
        chk(!rdRespValid, "t5_wait_rst_valid", 64'(rdRespValid), 64'd0);
        repeat (2) tick();
        wrReqValid = 1'b0;
        rst_n      = 1'b1;
        repeat (4) tick();
        // 5b: reset in RD_HOLD with a write pending
        rdRespReady = 1'b0;
        doRead(2'd1, 2'd2);
        tick();
        @(negedge clk);
        chk(rdRespValid, "t5_hold_valid", 64'(rdRespValid), 64'd1);
        #2;
        wrReqValid = 1'b1;
        rst_n      = 1'b0;
        #1;
        chk(!rdRespValid && isReading, "t5_hold_rst", {62'd0, rdRespValid, isReading}, 64'd1);
        repeat (2) tick();
        wrReqValid  = 1'b0;
        rst_n       = 1'b1;
        rdRespReady = 1'b1;
        repeat (4) tick();
        doRead(2'd2, 2'd1);
        drain();

        // 6: back-to-back reads of preloaded registers
        for (int i = 0; i < 4; i++) doWrite(2'(i), 64'(10 + i));
        idx        = 0;
        lastN      = 0;
        rdReqValid = 1'b1;
        rdSelA     = 2'd0;
        rdSelB     = 2'd0;
        for (int n = 0; n < 40 && idx < 4; n++) begin
            @(negedge clk);
            if (rdReqReady) begin
                if (idx > 0) chk(n - lastN == 2, "t6_interval", 64'(n - lastN), 64'd2);
                lastN = n;
                idx++;
            end
            tick();
            rdSelA = 2'(idx);
            rdSelB = 2'(idx);
        end
        chk(idx == 4, "t6_all_issued", 64'(idx), 64'd4);
        rdReqValid = 1'b0;
        drain();

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            rdReqValid  = 1'($urandom_range(1));
            wrReqValid  = 1'($urandom_range(1));
            rdRespReady = ($urandom_range(3) != 0);
            rdSelA      = 2'($urandom_range(3));
            rdSelB      = 2'($urandom_range(3));
            wrSel       = 2'($urandom_range(3));
            wrData      = {$urandom, $urandom};
            tick();
        end
        rdReqValid  = 1'b0;
        wrReqValid  = 1'b0;
        rdRespReady = 1'b1;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
